// File: rtl/ycbcr_pkg.sv
// ycbcr_pkg: shared phase encoding and default frame geometry for the CbYCrY byte parser.
`default_nettype none

package ycbcr_pkg;

    typedef enum logic [1:0] {
        PH_CB = 2'd0,
        PH_Y0 = 2'd1,
        PH_CR = 2'd2,
        PH_Y1 = 2'd3
    } phase_t;

    localparam int DEFAULT_MAX_WIDTH  = 640;
    localparam int DEFAULT_MAX_HEIGHT = 480;

endpackage

`default_nettype wire

// File: rtl/ycbcr_parser.sv
// ycbcr_parser: assembles Cb,Y0,Cr,Y1 byte groups into pixel pairs and tracks x/y position.
// Optional macro YCBCR_PARSER_ERR_CNT_EN adds a saturating 16-bit phase-error counter (err_count).
`default_nettype none

module ycbcr_parser
    import ycbcr_pkg::*;
#(
    parameter int MAX_WIDTH  = DEFAULT_MAX_WIDTH,
    parameter int MAX_HEIGHT = DEFAULT_MAX_HEIGHT
) (
    input  logic        pix_clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        frame_start_in,
    input  logic        line_start_in,
    input  logic        line_end_in,
    output logic [7:0]  y0,
    output logic [7:0]  cb,
    output logic [7:0]  y1,
    output logic [7:0]  cr,
    output logic        pair_valid,
    output logic        sof,
    output logic [9:0]  x_pos,
    output logic [8:0]  y_pos,
    output logic        eol,
`ifdef YCBCR_PARSER_ERR_CNT_EN
    output logic [15:0] err_count,
`endif
    output logic        phase_err
);

    localparam logic [9:0] X_LAST = 10'(MAX_WIDTH - 2);
    localparam logic [8:0] Y_LAST = 9'(MAX_HEIGHT - 1);

    phase_t     phase;
    phase_t     phase_base;
    phase_t     phase_next;
    logic       accept;
    logic       pair_emit;
    logic       group_err;
    logic       sof_armed;
    logic       frame_done;
    logic [7:0] cap_cb;
    logic [7:0] cap_y0;
    logic [7:0] cap_cr;

    // Start markers realign before the byte is consumed; line_end is judged after it.
    always_comb begin
        phase_base = (frame_start_in || line_start_in) ? PH_CB : phase;
        accept     = byte_valid && (!frame_done || frame_start_in);
        pair_emit  = accept && (phase_base == PH_Y1);
        phase_next = phase_base;
        if (accept) begin
            case (phase_base)
                PH_CB:   phase_next = PH_Y0;
                PH_Y0:   phase_next = PH_CR;
                PH_CR:   phase_next = PH_Y1;
                default: phase_next = PH_CB;
            endcase
        end
        group_err = line_end_in && (phase_next != PH_CB);
        if (line_end_in) begin
            phase_next = PH_CB;
        end
    end

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            phase <= PH_CB;
        end else begin
            phase <= phase_next;
        end
    end

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            cap_cb     <= '0;
            cap_y0     <= '0;
            cap_cr     <= '0;
            cb         <= '0;
            y0         <= '0;
            cr         <= '0;
            y1         <= '0;
            pair_valid <= 1'b0;
            sof        <= 1'b0;
            sof_armed  <= 1'b0;
            eol        <= 1'b0;
            phase_err  <= 1'b0;
            x_pos      <= '0;
            y_pos      <= '0;
            frame_done <= 1'b0;
        end else begin
            pair_valid <= pair_emit;
            sof        <= pair_emit && sof_armed;
            eol        <= line_end_in;
            phase_err  <= group_err;

            if (accept) begin
                case (phase_base)
                    PH_CB: cap_cb <= byte_in;
                    PH_Y0: cap_y0 <= byte_in;
                    PH_CR: cap_cr <= byte_in;
                    default: begin
                        cb <= cap_cb;
                        y0 <= cap_y0;
                        cr <= cap_cr;
                        y1 <= byte_in;
                    end
                endcase
            end

            if (pair_emit) begin
                sof_armed <= 1'b0;
            end
            if (frame_start_in) begin
                sof_armed <= 1'b1;
            end

            // x_pos names the column of the pair on the outputs, so it steps after that pair.
            if (frame_start_in || line_start_in) begin
                x_pos <= '0;
            end else if (pair_valid && (x_pos < X_LAST)) begin
                x_pos <= x_pos + 10'd2;
            end

            if (frame_start_in) begin
                y_pos      <= '0;
                frame_done <= 1'b0;
            end else if (line_end_in) begin
                if (y_pos < Y_LAST) begin
                    y_pos <= y_pos + 9'd1;
                end else begin
                    frame_done <= 1'b1;
                end
            end
        end
    end

`ifdef YCBCR_PARSER_ERR_CNT_EN
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (group_err && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire
